// File: rtl/txll_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | txll_pkg : shared widths and flag positions for the TX link FIFO path  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package txll_pkg;
  localparam int C_EOF_BIT   = 34;
  localparam int TXLL_WORD_W = 36;
  localparam int TXLL_CNT_W  = 10;
endpackage
`default_nettype wire

// File: rtl/txll_fifo_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | txll_fifo_ram : dual-port storage, synchronous write, async read       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module txll_fifo_ram
  import txll_pkg::*;
#(
  parameter int C_DEPTH = 512,
  parameter int C_WIDTH = TXLL_WORD_W,
  parameter int C_AW    = $clog2(C_DEPTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [C_AW-1:0]    i_wr_addr,
  input  logic [C_WIDTH-1:0] i_wr_data,
  input  logic [C_AW-1:0]    i_rd_addr,
  output logic [C_WIDTH-1:0] o_rd_data
);

  logic [C_WIDTH-1:0] r_mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/txll_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | txll_sync_fifo : single-clock FWFT FIFO with thresholds and EOF track  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module txll_sync_fifo
  import txll_pkg::*;
#(
  parameter int C_DEPTH     = 512,
  parameter int C_WIDTH     = TXLL_WORD_W,
  parameter int C_AF_THRESH = 256,
  parameter int C_AE_THRESH = 128,
  parameter int C_EOF_POS   = C_EOF_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [C_WIDTH-1:0]    i_wr_di,
  input  logic                  i_wr_en,
  output logic                  o_wr_full,
  output logic                  o_wr_almost_full,
  output logic [TXLL_CNT_W-1:0] o_wr_count,
  output logic                  o_wr_err,
  output logic                  o_wr_eof_poped,
  output logic [C_WIDTH-1:0]    o_rd_do,
  input  logic                  i_rd_en,
  output logic                  o_rd_empty,
  output logic                  o_rd_almost_empty,
  output logic [TXLL_CNT_W-1:0] o_rd_count,
  output logic                  o_rd_err,
  output logic                  o_rd_eof_rdy
);

  localparam int c_ptr_w = $clog2(C_DEPTH);
  localparam logic [TXLL_CNT_W-1:0] c_depth_cnt = TXLL_CNT_W'(C_DEPTH);
  localparam logic [TXLL_CNT_W-1:0] c_af_cnt    = TXLL_CNT_W'(C_AF_THRESH);
  localparam logic [TXLL_CNT_W-1:0] c_ae_cnt    = TXLL_CNT_W'(C_AE_THRESH);
  localparam logic [TXLL_CNT_W-1:0] c_one_cnt   = TXLL_CNT_W'(1);

  logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [TXLL_CNT_W-1:0] r_count, w_count_nxt, r_eof_cnt, w_eof_nxt;
  logic                  r_full, r_af, r_empty, r_ae, r_werr, r_rerr, r_eof_rdy, r_eof_poped;
  logic [C_WIDTH-1:0]    r_rd_do, w_ram_do;
  logic                  w_push, w_pop, w_inc_eof, w_dec_eof;

  txll_fifo_ram #(
    .C_DEPTH (C_DEPTH),
    .C_WIDTH (C_WIDTH),
    .C_AW    (c_ptr_w)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_wr_di),
    .i_rd_addr (w_rd_ptr_nxt),
    .o_rd_data (w_ram_do)
  );

  always_comb begin
    w_push       = i_wr_en && !r_full;
    w_pop        = i_rd_en && !r_empty;
    w_inc_eof    = w_push && i_wr_di[C_EOF_POS];
    w_dec_eof    = w_pop && r_rd_do[C_EOF_POS];
    w_rd_ptr_nxt = w_pop ? r_rd_ptr + c_ptr_w'(1) : r_rd_ptr;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_one_cnt;
      2'b01:   w_count_nxt = r_count - c_one_cnt;
      default: w_count_nxt = r_count;
    endcase
    case ({w_inc_eof, w_dec_eof})
      2'b10:   w_eof_nxt = r_eof_cnt + c_one_cnt;
      2'b01:   w_eof_nxt = r_eof_cnt - c_one_cnt;
      default: w_eof_nxt = r_eof_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_eof_cnt   <= '0;
      r_full      <= 1'b0;
      r_af        <= 1'b0;
      r_empty     <= 1'b1;
      r_ae        <= 1'b1;
      r_werr      <= 1'b0;
      r_rerr      <= 1'b0;
      r_eof_rdy   <= 1'b0;
      r_eof_poped <= 1'b0;
      r_rd_do     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == c_depth_cnt);
      r_af        <= (w_count_nxt >= c_af_cnt);
      r_empty     <= (w_count_nxt == '0);
      r_ae        <= (w_count_nxt <= c_ae_cnt);
      r_werr      <= i_wr_en && r_full;
      r_rerr      <= i_rd_en && r_empty;
      r_eof_cnt   <= w_eof_nxt;
      r_eof_rdy   <= (w_eof_nxt != '0);
      r_eof_poped <= w_dec_eof;
      // The RAM cannot return a word written on this same edge, so bypass it
      // when the incoming word becomes the new head.
      if (w_push && (w_count_nxt == c_one_cnt)) begin
        r_rd_do <= i_wr_di;
      end else if (w_count_nxt != '0) begin
        r_rd_do <= w_ram_do;
      end
    end
  end

  assign o_wr_full         = r_full;
  assign o_wr_almost_full  = r_af;
  assign o_wr_count        = r_count;
  assign o_wr_err          = r_werr;
  assign o_wr_eof_poped    = r_eof_poped;
  assign o_rd_do           = r_rd_do;
  assign o_rd_empty        = r_empty;
  assign o_rd_almost_empty = r_ae;
  assign o_rd_count        = r_count;
  assign o_rd_err          = r_rerr;
  assign o_rd_eof_rdy      = r_eof_rdy;

endmodule
`default_nettype wire

// File: tb/tb_txll_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_txll_sync_fifo : directed + random bench against a queue model     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_txll_sync_fifo;

  localparam int D = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] wr_di;
  logic        wr_en, rd_en;
  logic        wr_full, wr_af, wr_err, wr_eof_poped;
  logic [9:0]  wr_count, rd_count;
  logic [35:0] rd_do;
  logic        rd_empty, rd_ae, rd_err, rd_eof_rdy;

  txll_sync_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .i_wr_di           (wr_di),
    .i_wr_en           (wr_en),
    .o_wr_full         (wr_full),
    .o_wr_almost_full  (wr_af),
    .o_wr_count        (wr_count),
    .o_wr_err          (wr_err),
    .o_wr_eof_poped    (wr_eof_poped),
    .o_rd_do           (rd_do),
    .i_rd_en           (rd_en),
    .o_rd_empty        (rd_empty),
    .o_rd_almost_empty (rd_ae),
    .o_rd_count        (rd_count),
    .o_rd_err          (rd_err),
    .o_rd_eof_rdy      (rd_eof_rdy)
  );

  always #5 clk = ~clk;

  // reference model: the FIFO contents as a plain queue
  logic [35:0] q[$];
  int          eofs;
  logic [35:0] exp_do;
  logic        exp_werr, exp_rerr, exp_eofp;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_eofp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    eofs     = 0;
    exp_do   = '0;
    exp_werr = 1'b0;
    exp_rerr = 1'b0;
    exp_eofp = 1'b0;
  endtask

  task automatic check_outputs(input string p);
    int n;
    n = q.size();
    chk({p, ".wr_count"}, 64'(wr_count), 64'(n));
    chk({p, ".rd_count"}, 64'(rd_count), 64'(n));
    chk({p, ".empty"},    64'(rd_empty), 64'(n == 0));
    chk({p, ".full"},     64'(wr_full),  64'(n == D));
    chk({p, ".afull"},    64'(wr_af),    64'(n >= 256));
    chk({p, ".aempty"},   64'(rd_ae),    64'(n <= 128));
    chk({p, ".eof_rdy"},  64'(rd_eof_rdy), 64'(eofs > 0));
    chk({p, ".wr_err"},   64'(wr_err),   64'(exp_werr));
    chk({p, ".rd_err"},   64'(rd_err),   64'(exp_rerr));
    chk({p, ".eof_pop"},  64'(wr_eof_poped), 64'(exp_eofp));
    chk({p, ".rd_do"},    64'(rd_do),    64'(exp_do));
  endtask

  task automatic cycle(input logic we, input logic [35:0] di, input logic re);
    int  n;
    logic do_push, do_pop;
    wr_en = we;
    wr_di = di;
    rd_en = re;
    @(posedge clk);
    n        = q.size();
    do_push  = we && (n < D);
    do_pop   = re && (n > 0);
    exp_werr = we && (n == D);
    exp_rerr = re && (n == 0);
    exp_eofp = do_pop && q[0][34];
    if (do_pop) begin
      if (q[0][34]) eofs--;
      void'(q.pop_front());
    end
    if (do_push) begin
      q.push_back(di);
      if (di[34]) eofs++;
    end
    if (q.size() > 0) exp_do = q[0];
    #1;
    if (wr_eof_poped) n_eofp++;
    check_outputs("cyc");
  endtask

  task automatic async_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    @(posedge clk);
    #1;
    check_outputs("arst_hold");
    rst = 1'b0;
  endtask

  initial begin
    logic [35:0] w;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_di = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // single EOF word through the FIFO
    cycle(1'b1, 36'h4_DEAD_BEEF, 1'b0);
    chk("single.rd_do", 64'(rd_do), 64'h4_DEAD_BEEF);
    n_eofp = 0;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("single.eof_pulses", 64'(n_eofp), 64'd1);

    // fill, overflow, drain in order
    for (int i = 0; i < D; i++) cycle(1'b1, 36'(i), 1'b0);
    cycle(1'b1, 36'h0_0000_0200, 1'b0);
    chk("ovf.count", 64'(wr_count), 64'd512);
    for (int i = 0; i < D; i++) begin
      chk("drain.order", 64'(rd_do), 64'(i));
      cycle(1'b0, '0, 1'b1);
    end

    // steady occupancy 300 with pointer wrap
    for (int i = 0; i < 300; i++) cycle(1'b1, 36'(i), 1'b0);
    for (int i = 0; i < 1000; i++) cycle(1'b1, {4'($urandom), 32'($urandom)}, 1'b1);
    chk("steady.count", 64'(rd_count), 64'd300);

    // top up to full, then simultaneous push and pop while full
    for (int i = 0; i < 212; i++) cycle(1'b1, 36'(i), 1'b0);
    cycle(1'b1, 36'h1_2345_6789, 1'b1);
    chk("fullrw.count", 64'(wr_count), 64'd511);
    for (int i = 0; i < 512; i++) cycle(1'b0, '0, 1'b1);

    // reset mid-burst with two EOF words queued
    for (int i = 0; i < 37; i++) begin
      w = 36'(i);
      w[34] = (i == 10) || (i == 20);
      cycle(1'b1, w, 1'b0);
    end
    async_reset();

    // three frames, EOF at positions 5, 9, 20
    for (int i = 0; i < 21; i++) begin
      w = 36'(i + 100);
      w[34] = (i == 5) || (i == 9) || (i == 20);
      cycle(1'b1, w, 1'b0);
    end
    n_eofp = 0;
    for (int i = 0; i < 22; i++) cycle(1'b0, '0, 1'b1);
    chk("frames.eof_pulses", 64'(n_eofp), 64'd3);

    // random traffic with shifting write/read bias
    for (int b = 0; b < 6; b++) begin
      int wp, rp;
      wp = (b % 2 == 0) ? 80 : 35;
      rp = (b % 2 == 0) ? 35 : 80;
      for (int i = 0; i < 700; i++) begin
        w = {4'($urandom), 32'($urandom)};
        w[34] = ($urandom_range(0, 7) == 0);
        cycle($urandom_range(0, 99) < wp, w, $urandom_range(0, 99) < rp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
